instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Sequential fetch front end of the LEGv8 datapath, the consumer of the next-PC selection. It holds the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and forwards each returned 32-bit instruction with its PC to decode over a valid/ready channel. A redirect from branch resolution reloads the PC with the branch target and squashes any wrong-path fetch.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset (must be 4-byte aligned)
- CLK  input  1  rising-edge clock
- Reset_L  input  1  asynchronous, active-low reset
- ImemReqValid  output  1  fetch request valid
- ImemReqReady  input  1  memory accepts request this cycle
- ImemAddr  output  64  fetch address, registered
- ImemRspValid  input  1  read data valid, exactly one per accepted request
- ImemRspData  input  32  instruction word
- InstrValid  output  1  instruction available to decode
- InstrReady  input  1  decode accepts instruction
- Instr  output  32  fetched instruction
- InstrPC  output  64  address of Instr
- Redirect  input  1  branch taken/unconditional, single-cycle pulse
- RedirectPC  input  64  target, CurrentPC + SignExtImm64
- Fault  output  1  misaligned redirect (see Configuration)

## Operation
- States: IDLE, REQ, WAIT, HOLD, FAULT. Reset state IDLE; at most one outstanding request.
- IDLE: one cycle after reset release, then REQ.
- REQ: ImemReqValid=1, ImemAddr=PC. On ImemReqReady: capture ReqPC=PC, PC<=PC+4, go WAIT.
- WAIT: on ImemRspValid: if Squash, discard data, clear Squash, go REQ; else latch Instr=ImemRspData, InstrPC=ReqPC, go HOLD.
- HOLD: InstrValid=1, Instr/InstrPC stable. On InstrReady go REQ.
- Redirect (priority over all normal transitions, every state except FAULT/IDLE):
  - PC<=RedirectPC.
  - REQ with ImemReqReady same cycle: request is wrong-path; go WAIT with Squash=1. REQ without ready: stay REQ; ImemAddr shows new PC next cycle (memory must not rely on address stability across a redirect).
  - WAIT: Squash<=1; if ImemRspValid same cycle, response discarded and go REQ directly.
  - HOLD: InstrValid drops next cycle, go REQ. Redirect with InstrReady same cycle: instruction counts as consumed; same result.
- IDLE with Redirect: PC loaded, next state REQ.
- PC arithmetic: unsigned 64-bit, +4 wraps 64'hFFFF_FFFF_FFFF_FFFC to 0; no other width handling.
- Reset mid-operation: all state cleared immediately; any response arriving after reset release with no outstanding request is ignored.

## Timing
- Reset values: ImemReqValid=0, ImemAddr=RESET_PC, InstrValid=0, Instr=0, InstrPC=0, Fault=0, Squash=0, PC=RESET_PC.
- All outputs registered/state-decoded; no combinational input-to-output paths.
- Request accepted at edge t; response earliest cycle t+1; InstrValid earliest one cycle after response.
- Steady state with ready memory (1-cycle response) and ready decode: one instruction per 3 cycles.
- Redirect at edge t: first request to target presented cycle t+1 (REQ/HOLD) or one cycle after the squashed response (WAIT).

## Configuration
- IFETCH_MISALIGN_CHECK_EN defined: Redirect with RedirectPC[1:0]!=0 enters FAULT; Fault=1, ImemReqValid=0, InstrValid=0, outstanding response discarded; exit only by reset.
- Undefined: RedirectPC[1:0] ignored, PC loaded as {RedirectPC[63:2],2'b00}; FAULT unreachable; Fault tied 0.

## Structure
- Package ifetch_pkg: state enum, INSTR_W=32, PC_W=64, PC_INC=64'd4.
- One sub-module fetch_pc_reg: PC register with async reset to RESET_PC, load (redirect) and increment controls.

## Test plan
- Reset, memory always ready, 1-cycle response: requests at 0x0, 0x4, 0x8; InstrPC matches; InstrValid every 3rd cycle.
- Decode holds InstrReady=0 for 5 cycles: Instr/InstrPC stable, no new ImemReqValid until accepted.
- Redirect to 0x100 during WAIT for 0x8: response for 0x8 never reaches decode; next request 0x100.
- Redirect to 0x200 same cycle as request 0xC accepted: 0xC response squashed; next InstrPC 0x200.
- PC=64'hFFFF_FFFF_FFFF_FFFC fetched: next request address 0x0.
- Macro on: Redirect to 0x102: Fault=1 next cycle, no further requests until Reset_L pulse; macro off: next request 0x100.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch front end.
//   fetch_state_e : fetch sequencer states
//   INSTR_W       : instruction word width
//   PC_W          : program counter width
//   PC_INC        : sequential PC step
//   PC_ALIGN_MASK : clears the byte-offset bits of a redirect target
package ifetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 64;

    localparam logic [PC_W-1:0] PC_INC        = 64'd4;
    localparam logic [PC_W-1:0] PC_ALIGN_MASK = ~64'h3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch front end.
//   i_clk     : rising-edge clock
//   i_rst_n   : asynchronous active-low reset, loads RESET_PC
//   i_load    : load i_load_pc (redirect), wins over increment
//   i_load_pc : redirect target, already word aligned
//   i_inc     : advance by PC_INC (wraps modulo 2^64)
//   o_pc      : current program counter
module fetch_pc_reg
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_load_pc,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    // Redirect load has priority over sequential advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_INC;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Sequential instruction fetch front end: holds the PC, issues one
// instruction-memory read at a time and hands each returned word with its
// PC to decode. A branch redirect reloads the PC and squashes wrong-path data.
//
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN
//   defined   : a redirect to a non word-aligned target enters FAULT
//               (Fault=1, no requests, no instructions) until reset.
//   undefined : target bits [1:0] are dropped; Fault is tied low.
//
// Ports
//   CLK, Reset_L                 : clock, async active-low reset
//   ImemReqValid/Ready, ImemAddr : instruction-memory request channel
//   ImemRspValid, ImemRspData    : one response per accepted request
//   InstrValid/Ready, Instr,
//   InstrPC                      : decode channel
//   Redirect, RedirectPC         : single-cycle branch redirect
//   Fault                        : misaligned-redirect fault
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                CLK,
    input  logic                Reset_L,
    output logic                ImemReqValid,
    input  logic                ImemReqReady,
    output logic [PC_W-1:0]     ImemAddr,
    input  logic                ImemRspValid,
    input  logic [INSTR_W-1:0]  ImemRspData,
    output logic                InstrValid,
    input  logic                InstrReady,
    output logic [INSTR_W-1:0]  Instr,
    output logic [PC_W-1:0]     InstrPC,
    input  logic                Redirect,
    input  logic [PC_W-1:0]     RedirectPC,
    output logic                Fault
);

    fetch_state_e       r_state;
    logic [PC_W-1:0]    r_req_pc;
    logic [PC_W-1:0]    r_instr_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_squash;
    logic               r_req_valid;
    logic               r_instr_valid;

    logic [PC_W-1:0]    w_pc;
    logic [PC_W-1:0]    w_target;
    logic               w_redirect_live;
    logic               w_pc_load;
    logic               w_pc_inc;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic               w_bad_redirect;
    logic               r_fault;
`endif

    // PC controls: redirect honoured in every state but FAULT; advance on an
    // accepted request that is not being overridden by a redirect.
    always_comb begin
        w_redirect_live = Redirect && (r_state != FAULT);
        w_target        = RedirectPC & PC_ALIGN_MASK;
`ifdef IFETCH_MISALIGN_CHECK_EN
        w_bad_redirect  = w_redirect_live && (RedirectPC[1:0] != 2'b00);
        w_pc_load       = w_redirect_live && !w_bad_redirect;
`else
        w_pc_load       = w_redirect_live;
`endif
        w_pc_inc        = (r_state == REQ) && ImemReqReady && !Redirect;
    end

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk     (CLK),
        .i_rst_n   (Reset_L),
        .i_load    (w_pc_load),
        .i_load_pc (w_target),
        .i_inc     (w_pc_inc),
        .o_pc      (w_pc)
    );

    // Fetch sequencer with registered handshake outputs.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state       <= IDLE;
            r_req_pc      <= RESET_PC;
            r_instr_pc    <= '0;
            r_instr       <= '0;
            r_squash      <= 1'b0;
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
            r_fault       <= 1'b0;
`endif
        end else begin
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (w_bad_redirect) begin
                // Any outstanding response is ignored from here on.
                r_state       <= FAULT;
                r_fault       <= 1'b1;
                r_req_valid   <= 1'b0;
                r_instr_valid <= 1'b0;
                r_squash      <= 1'b0;
            end else begin
`endif
            case (r_state)
                IDLE: begin
                    r_state     <= REQ;
                    r_req_valid <= 1'b1;
                end
                REQ: begin
                    if (Redirect) begin
                        // Accepted request is wrong-path; without ready we
                        // simply re-present at the new PC next cycle.
                        if (ImemReqReady) begin
                            r_state     <= WAIT;
                            r_squash    <= 1'b1;
                            r_req_valid <= 1'b0;
                        end
                    end else if (ImemReqReady) begin
                        r_req_pc    <= w_pc;
                        r_state     <= WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (Redirect) begin
                        if (ImemRspValid) begin
                            r_squash    <= 1'b0;
                            r_state     <= REQ;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_squash    <= 1'b1;
                        end
                    end else if (ImemRspValid) begin
                        if (r_squash) begin
                            r_squash    <= 1'b0;
                            r_state     <= REQ;
                            r_req_valid <= 1'b1;
                        end else begin
                            r_instr       <= ImemRspData;
                            r_instr_pc    <= r_req_pc;
                            r_state       <= HOLD;
                            r_instr_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Redirect with or without acceptance ends the hold.
                    if (Redirect || InstrReady) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= REQ;
                        r_req_valid   <= 1'b1;
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state       <= IDLE;
                    r_req_valid   <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_squash      <= 1'b0;
                end
            endcase
`ifdef IFETCH_MISALIGN_CHECK_EN
            end
`endif
        end
    end

    assign ImemReqValid = r_req_valid;
    assign ImemAddr     = w_pc;
    assign InstrValid   = r_instr_valid;
    assign Instr        = r_instr;
    assign InstrPC      = r_instr_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
    assign Fault        = r_fault;
`else
    assign Fault        = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized traffic against a program-order reference model.
module tb_instruction_fetch;

    localparam logic [63:0] RST_PC = 64'h0;

    logic        CLK;
    logic        Reset_L;
    logic        ImemReqValid;
    logic        ImemReqReady;
    logic [63:0] ImemAddr;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic        InstrValid;
    logic        InstrReady;
    logic [31:0] Instr;
    logic [63:0] InstrPC;
    logic        Redirect;
    logic [63:0] RedirectPC;
    logic        Fault;

    instruction_fetch #(
        .RESET_PC (RST_PC)
    ) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .ImemReqValid (ImemReqValid),
        .ImemReqReady (ImemReqReady),
        .ImemAddr     (ImemAddr),
        .ImemRspValid (ImemRspValid),
        .ImemRspData  (ImemRspData),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .Fault        (Fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Environment knobs
    int unsigned mem_rdy_pct = 100;
    int unsigned dec_rdy_pct = 100;
    int unsigned lat_max     = 1;

    // Memory / program-order model state
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_data;
    logic [63:0] exp_req;
    logic [63:0] exp_pc;
    logic        hold_chk;
    logic [63:0] held_pc;
    logic [31:0] held_instr;
    logic        faulted;
    int unsigned n_acc;
    int unsigned n_cons;
    logic [63:0] last_acc_addr;
    logic [63:0] last_cons_pc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock cycle: entered and left just after a falling edge.
    task automatic tick(input logic redir, input logic [63:0] tgt);
        logic        acc, cons, rsp, iv_obs;
        logic [63:0] addr_obs, pc_obs;
        logic [31:0] instr_obs;
        ImemReqReady = ($urandom_range(99) < mem_rdy_pct);
        rsp          = pend && (pend_cnt == 0);
        ImemRspValid = rsp;
        ImemRspData  = rsp ? pend_data : $urandom();
        InstrReady   = ($urandom_range(99) < dec_rdy_pct);
        Redirect     = redir;
        RedirectPC   = tgt;
        acc       = ImemReqValid && ImemReqReady;
        cons      = InstrValid && InstrReady;
        iv_obs    = InstrValid;
        addr_obs  = ImemAddr;
        pc_obs    = InstrPC;
        instr_obs = Instr;
        @(posedge CLK);
        if (rsp) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (acc) begin
            chk1("one_outstanding", pend, 1'b0);
            chk("req_addr", addr_obs, exp_req);
            exp_req       = exp_req + 64'd4;
            pend          = 1'b1;
            pend_cnt      = int'($urandom_range(lat_max - 1));
            pend_data     = mem_word(addr_obs);
            last_acc_addr = addr_obs;
            n_acc++;
        end
        if (cons) begin
            chk("instr_pc", pc_obs, exp_pc);
            chk("instr_word", 64'(instr_obs), 64'(mem_word(exp_pc)));
            exp_pc       = exp_pc + 64'd4;
            last_cons_pc = pc_obs;
            n_cons++;
        end
        if (redir && !faulted) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) faulted = 1'b1;
            else
`endif
            begin
                exp_req = {tgt[63:2], 2'b00};
                exp_pc  = {tgt[63:2], 2'b00};
            end
        end
        hold_chk   = iv_obs && !InstrReady && !redir && !faulted;
        held_pc    = pc_obs;
        held_instr = instr_obs;
        @(negedge CLK);
        if (hold_chk) begin
            chk1("hold_valid", InstrValid, 1'b1);
            chk("hold_pc", InstrPC, held_pc);
            chk("hold_instr", 64'(Instr), 64'(held_instr));
        end
        chk1("no_req_with_instr", ImemReqValid && InstrValid, 1'b0);
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (faulted) begin
            chk1("fault_flag", Fault, 1'b1);
            chk1("fault_no_req", ImemReqValid, 1'b0);
            chk1("fault_no_instr", InstrValid, 1'b0);
        end else begin
            chk1("fault_flag", Fault, 1'b0);
        end
`else
        chk1("fault_flag", Fault, 1'b0);
`endif
    endtask

    // Asynchronous reset pulse, stray response while idle, first request.
    task automatic do_reset();
        #2 Reset_L = 1'b0;
        #1;
        chk1("rst_req_valid", ImemReqValid, 1'b0);
        chk1("rst_instr_valid", InstrValid, 1'b0);
        chk1("rst_fault", Fault, 1'b0);
        chk("rst_addr", ImemAddr, RST_PC);
        chk("rst_instr", 64'(Instr), 64'h0);
        chk("rst_instr_pc", InstrPC, 64'h0);
        Redirect     = 1'b0;
        RedirectPC   = '0;
        ImemReqReady = 1'b0;
        ImemRspValid = 1'b0;
        InstrReady   = 1'b0;
        pend     = 1'b0;
        pend_cnt = 0;
        hold_chk = 1'b0;
        faulted  = 1'b0;
        exp_req  = RST_PC;
        exp_pc   = RST_PC;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset_L      = 1'b1;
        ImemRspValid = 1'b1;
        ImemRspData  = $urandom();
        @(negedge CLK);
        ImemRspValid = 1'b0;
        chk1("first_req_valid", ImemReqValid, 1'b1);
        chk("first_req_addr", ImemAddr, RST_PC);
        chk1("first_instr_valid", InstrValid, 1'b0);
    endtask

    initial begin
        int unsigned c0;
        logic [63:0] tgt;
        Reset_L      = 1'b0;
        Redirect     = 1'b0;
        RedirectPC   = '0;
        ImemReqReady = 1'b0;
        ImemRspValid = 1'b0;
        ImemRspData  = '0;
        InstrReady   = 1'b0;
        n_acc        = 0;
        n_cons       = 0;
        last_acc_addr = '0;
        last_cons_pc  = '0;
        @(negedge CLK);
        do_reset();

        // Sequential fetch with ready memory and decode: 1 instr / 3 cycles
        repeat (6) tick(1'b0, '0);
        c0 = n_cons;
        repeat (30) tick(1'b0, '0);
        chk("throughput", 64'(n_cons - c0), 64'd10);

        // Decode stall for 5 cycles
        dec_rdy_pct = 0;
        for (int i = 0; i < 20 && !InstrValid; i++) tick(1'b0, '0);
        chk1("stall_reach", InstrValid, 1'b1);
        repeat (5) tick(1'b0, '0);
        chk1("stall_no_req", ImemReqValid, 1'b0);
        dec_rdy_pct = 100;

        // Redirect to 0x100 while waiting on the response for 0x8
        do_reset();
        for (int i = 0; i < 30 && !(pend && last_acc_addr == 64'h8); i++) tick(1'b0, '0);
        chk1("reach_wait8", pend && (last_acc_addr == 64'h8), 1'b1);
        tick(1'b1, 64'h100);
        chk1("redir_wait_valid", ImemReqValid, 1'b1);
        chk("redir_wait_addr", ImemAddr, 64'h100);
        c0 = n_cons;
        for (int i = 0; i < 20 && n_cons == c0; i++) tick(1'b0, '0);
        chk("redir_wait_pc", last_cons_pc, 64'h100);

        // Redirect to 0x200 in the cycle request 0xC is accepted
        do_reset();
        for (int i = 0; i < 30 && !(ImemReqValid && ImemAddr == 64'hC); i++) tick(1'b0, '0);
        chk1("reach_req_c", ImemReqValid && (ImemAddr == 64'hC), 1'b1);
        tick(1'b1, 64'h200);
        c0 = n_cons;
        for (int i = 0; i < 20 && n_cons == c0; i++) tick(1'b0, '0);
        chk("squash_next_pc", last_cons_pc, 64'h200);

        // PC wrap from the top of the address space
        tick(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        c0 = n_cons;
        for (int i = 0; i < 30 && (n_cons - c0) < 2; i++) tick(1'b0, '0);
        chk("wrap_to_zero", last_cons_pc, 64'h0);

        // Misaligned redirect target
        c0 = n_acc;
        tick(1'b1, 64'h102);
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk1("misalign_fault", Fault, 1'b1);
        c0 = n_acc;
        repeat (6) tick(1'b0, '0);
        chk("fault_no_accepts", 64'(n_acc - c0), 64'd0);
        do_reset();
`else
        c0 = n_acc;
        for (int i = 0; i < 20 && n_acc == c0; i++) tick(1'b0, '0);
        chk("misalign_aligned", last_acc_addr, 64'h100);
`endif

        // Randomized traffic with redirects and occasional resets
        mem_rdy_pct = 70;
        dec_rdy_pct = 70;
        lat_max     = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999) < (faulted ? 32'd100 : 32'd3)) begin
                do_reset();
            end else if ($urandom_range(99) < 4) begin
                case ($urandom_range(3))
                    0:       tgt = {$urandom(), $urandom()} & ~64'h3;
                    1:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'(4 * $urandom_range(3));
                    2:       tgt = 64'($urandom_range(16'hFFFF)) & ~64'h3;
                    default: tgt = (64'($urandom_range(16'hFFFF)) & ~64'h3) | 64'($urandom_range(3, 1));
                endcase
                tick(1'b1, tgt);
            end else begin
                tick(1'b0, '0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
